toggle_pulse_gen: RTL and testbench

Conditions a raw, asynchronous push-button or toggle-request line into a clean single-cycle `t_out` strobe. It sits directly upstream of the team's T flip-flop and drives its `t` input.
- Two-flop synchronizer, then a debounce state machine.
- One press produces exactly one toggle.
- An optional auto-repeat mode produces periodic toggles while the button is held.

---
 rtl/toggle_pkg.sv | 23 ++
 rtl/sync2.sv | 24 ++
 rtl/toggle_pulse_gen.sv | 136 +++++++++++++
 tb/tb_toggle_pulse_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/toggle_pkg.sv
// Shared types and defaults for the toggle pulse generator and its helpers.
package toggle_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } tpg_state_t;

   localparam int TPG_DEBOUNCE_DEF = 16;
   localparam int TPG_REPEAT_DEF   = 1000;

   // Debounced level is high once a press has been accepted until its release is accepted.
   function automatic logic tpg_level(input tpg_state_t st);
      return (st == HELD) || (st == RELEASE_WAIT);
   endfunction

   function automatic logic tpg_busy(input tpg_state_t st);
      return (st == PRESS_WAIT) || (st == RELEASE_WAIT);
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs; resets to 0.
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic f1;
   logic f2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f1 <= 1'b0;
         f2 <= 1'b0;
      end else begin
         f1 <= d;
         f2 <= f1;
      end
   end

   assign q = f2;

endmodule

// File: rtl/toggle_pulse_gen.sv
// Debounces a raw button into a one-cycle toggle strobe for a T flip-flop.
// Optional auto-repeat while held: define TOGGLE_PULSE_AUTOREPEAT_EN.
module toggle_pulse_gen
   import toggle_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = TPG_DEBOUNCE_DEF,
   parameter int CNT_W           = 16,
   parameter int REPEAT_CYCLES   = TPG_REPEAT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   input  logic en,
   output logic t_out,
   output logic level_out,
   output logic busy
);

   localparam int CNT_NEED = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2 || CNT_W < $clog2(CNT_NEED)) begin : g_param_check
      $error("toggle_pulse_gen: illegal DEBOUNCE_CYCLES/REPEAT_CYCLES/CNT_W combination");
   end

   logic             s;
   tpg_state_t       state;
   tpg_state_t       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             press_strobe;
   logic             rpt_strobe;

   sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_in),
      .q   (s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         t_out     <= 1'b0;
         level_out <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         // A strobe masked by en is simply lost; nothing remembers it.
         t_out     <= (press_strobe | rpt_strobe) & en;
         level_out <= tpg_level(state_nxt);
         busy      <= tpg_busy(state_nxt);
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      press_strobe = 1'b0;
      case (state)
         IDLE: begin
            if (s) begin
               state_nxt = PRESS_WAIT;
               cnt_nxt   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!s) begin
               state_nxt = IDLE;
            end else if (cnt == DB_LAST) begin
               state_nxt    = HELD;
               press_strobe = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         HELD: begin
            if (!s) begin
               state_nxt = RELEASE_WAIT;
               cnt_nxt   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (s) begin
               state_nxt = HELD;
            end else if (cnt == DB_LAST) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

`ifdef TOGGLE_PULSE_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES - 1);

   logic [CNT_W-1:0] rep_cnt;
   logic [CNT_W-1:0] rep_cnt_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_cnt <= '0;
      end else begin
         rep_cnt <= rep_cnt_nxt;
      end
   end

   // Counts only while HELD; frozen across a bounce through RELEASE_WAIT.
   always_comb begin
      rep_cnt_nxt = rep_cnt;
      rpt_strobe  = 1'b0;
      case (state)
         IDLE, PRESS_WAIT: rep_cnt_nxt = '0;
         HELD: begin
            if (rep_cnt == RP_LAST) begin
               rep_cnt_nxt = '0;
               rpt_strobe  = 1'b1;
            end else begin
               rep_cnt_nxt = rep_cnt + 1'b1;
            end
         end
         default: rep_cnt_nxt = rep_cnt;
      endcase
   end
`else
   assign rpt_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Directed self-checking bench for toggle_pulse_gen with DEBOUNCE_CYCLES=4.
module tb_toggle_pulse_gen;
   import toggle_pkg::*;

`ifdef TOGGLE_PULSE_AUTOREPEAT_EN
   localparam int RPT = 1;
`else
   localparam int RPT = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic btn_in;
   logic en;
   logic t_out;
   logic level_out;
   logic busy;

   int n_chk  = 0;
   int n_pass = 0;

   int   n_strobe;
   int   consec;
   int   lvl_min;
   int   lvl_max;
   int   busy_seen;
   logic prev_t;
   logic tq;

   toggle_pulse_gen #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (16),
      .REPEAT_CYCLES   (10)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_in    (btn_in),
      .en        (en),
      .t_out     (t_out),
      .level_out (level_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic clr_stats();
      n_strobe  = 0;
      lvl_min   = 1;
      lvl_max   = 0;
      busy_seen = 0;
   endtask

   // One clock edge, then observe on the following falling edge.
   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
      if (t_out) n_strobe++;
      if (t_out && prev_t) consec++;
      prev_t = t_out;
      if (t_out) tq = ~tq;
      if (int'(level_out) < lvl_min) lvl_min = int'(level_out);
      if (int'(level_out) > lvl_max) lvl_max = int'(level_out);
      if (busy) busy_seen = 1;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      rst    = 1'b1;
      btn_in = 1'b0;
      en     = 1'b1;
      consec = 0;
      prev_t = 1'b0;
      tq     = 1'b0;
      clr_stats();

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_t_out", int'(t_out), 0);
      check("rst_level", int'(level_out), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_state", int'(dut.state), int'(IDLE));

      // Press latency: strobe only after edge 6
      rst    = 1'b0;
      btn_in = 1'b1;
      for (int k = 0; k < 10; k++) begin
         cycle();
         check($sformatf("press_t_e%0d", k), int'(t_out), (k == 6) ? 1 : 0);
         check($sformatf("press_lvl_e%0d", k), int'(level_out), (k >= 6) ? 1 : 0);
         check($sformatf("press_busy_e%0d", k), int'(busy), (k >= 2 && k <= 5) ? 1 : 0);
      end
      btn_in = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         if (k == 5) check("rel_lvl_e5", int'(level_out), 1);
         if (k == 6) check("rel_lvl_e6", int'(level_out), 0);
      end
      check("rel_busy", int'(busy), 0);

      // Bounce rejection
      clr_stats();
      for (int r = 0; r < 5; r++) begin
         btn_in = 1'b1;
         cycles(3);
         btn_in = 1'b0;
         cycles(2);
      end
      cycles(8);
      check("bounce_strobes", n_strobe, 0);
      check("bounce_lvl", lvl_max, 0);
      check("bounce_busy_seen", busy_seen, 1);

      // Release and repress
      clr_stats();
      btn_in = 1'b1;
      cycles(20);
      check("hold_strobes", n_strobe, 1 + RPT);
      clr_stats();
      btn_in = 1'b0;
      cycles(2);
      btn_in = 1'b1;
      cycles(10);
      check("repress_strobes", n_strobe, RPT);
      check("repress_lvl_min", lvl_min, 1);
      btn_in = 1'b0;
      cycles(10);
      check("long_rel_lvl", int'(level_out), 0);
      clr_stats();
      btn_in = 1'b1;
      cycles(10);
      check("new_press_strobes", n_strobe, 1);
      btn_in = 1'b0;
      cycles(10);

      // Enable masking
      en = 1'b0;
      clr_stats();
      btn_in = 1'b1;
      cycles(10);
      check("en0_strobes", n_strobe, 0);
      check("en0_lvl", int'(level_out), 1);
      en = 1'b1;
      clr_stats();
      cycles(10);
      check("en1_late_strobes", n_strobe, RPT);
      btn_in = 1'b0;
      cycles(10);
      check("en_rel_lvl", int'(level_out), 0);

      // Asynchronous reset mid-qualification
      btn_in = 1'b1;
      cycles(5);
      check("pre_rst_busy", int'(busy), 1);
      check("pre_rst_cnt", int'(dut.cnt), 2);
      #2 rst = 1'b1;
      #1;
      check("arst_t_out", int'(t_out), 0);
      check("arst_level", int'(level_out), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_state", int'(dut.state), int'(IDLE));
      @(negedge clk);
      rst    = 1'b0;
      prev_t = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cycle();
         check($sformatf("post_rst_t_e%0d", k), int'(t_out), (k == 6) ? 1 : 0);
      end
      btn_in = 1'b0;
      cycles(10);

`ifdef TOGGLE_PULSE_AUTOREPEAT_EN
      // Auto-repeat while held, driving a T flip-flop model
      clr_stats();
      tq     = 1'b0;
      btn_in = 1'b1;
      for (int k = 0; k < 40; k++) begin
         cycle();
         check($sformatf("rpt_t_e%0d", k), int'(t_out),
               (k == 6 || k == 16 || k == 26 || k == 36) ? 1 : 0);
      end
      check("rpt_strobes", n_strobe, 4);
      check("rpt_tff_q", int'(tq), 0);
      btn_in = 1'b0;
      cycles(10);
`endif

      check("no_consecutive_strobes", consec, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
